// File: rtl/inst_fetch_ctrl_if.sv
// SRAM-like instruction bus between the IF fetch controller (master) and the
// instruction memory (slave).
interface inst_fetch_ctrl_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding bus read, wrong-path response discard, AdEF.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        fetch_pc,
    input  logic               fetch_en,
    input  logic               ID_stall,
    input  logic               flush,
    inst_fetch_ctrl_if.master  bus,
    output logic [31:0]        IF_inst,
    output logic [31:0]        IF_pc,
    output logic               IF_AdEF_exception,
    output logic [31:0]        IF_bad_inst,
    output logic               IF_stall,
    output logic               IF_invalid,
`ifdef IF_PERF_CNT_EN
    output logic [CNT_W-1:0]   perf_stall_cycles,
    output logic [CNT_W-1:0]   perf_cancel_cnt,
`endif
    output logic               pc_advance
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StReq    = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StCancel = 3'd3;
    localparam logic [2:0] StReady  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        cancel_q, cancel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] bad_q, bad_d;
    logic        adef_q, adef_d;
    logic        bv_q, bv_d;
    logic        discard;

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        addr_d   = addr_q;
        inst_d   = inst_q;
        pc_d     = pc_q;
        bad_d    = bad_q;
        adef_d   = adef_q;
        bv_d     = bv_q;
        discard  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fetch_en && !flush) begin
                    if (fetch_pc[1:0] != 2'b00) begin
                        // Misaligned PC never reaches the bus; hand over a faulting slot.
                        state_d = StReady;
                        adef_d  = 1'b1;
                        bad_d   = fetch_pc;
                        pc_d    = fetch_pc;
                        inst_d  = 32'h0;
                        bv_d    = 1'b1;
                    end else begin
                        addr_d  = fetch_pc;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                // The request cannot be withdrawn once raised; remember the flush.
                if (flush) cancel_d = 1'b1;
                if (bus.inst_addr_ok) state_d = (cancel_q || flush) ? StCancel : StWait;
            end
            StWait: begin
                if (bus.inst_data_ok) begin
                    if (flush) begin
                        state_d = StIdle;
                        discard = 1'b1;
                    end else begin
                        state_d = StReady;
                        inst_d  = bus.inst_rdata;
                        pc_d    = addr_q;
                        adef_d  = 1'b0;
                        bv_d    = 1'b1;
                    end
                end else if (flush) begin
                    state_d = StCancel;
                end
            end
            StCancel: begin
                if (bus.inst_data_ok) begin
                    state_d  = StIdle;
                    cancel_d = 1'b0;
                    discard  = 1'b1;
                end
            end
            StReady: begin
                if (flush || !ID_stall) begin
                    state_d = StIdle;
                    bv_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cancel_q <= 1'b0;
            addr_q   <= 32'h0;
            inst_q   <= 32'h0;
            pc_q     <= RESET_PC;
            bad_q    <= RESET_PC;
            adef_q   <= 1'b0;
            bv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
            pc_q     <= pc_d;
            bad_q    <= bad_d;
            adef_q   <= adef_d;
            bv_q     <= bv_d;
        end
    end

    assign bus.inst_req   = !rst && (state_q == StReq);
    assign bus.inst_wr    = 1'b0;
    assign bus.inst_size  = 2'b10;
    assign bus.inst_addr  = addr_q;
    assign bus.inst_wdata = 32'h0;

    assign IF_inst           = inst_q;
    assign IF_pc             = pc_q;
    assign IF_AdEF_exception = adef_q;
    assign IF_bad_inst       = bad_q;
    assign IF_stall          = !rst && (!bv_q || flush);
    assign IF_invalid        = !rst && (flush || (state_q == StCancel) || cancel_q);
    // Flush beats handover in the same cycle.
    assign pc_advance        = !rst && (state_q == StReady) && bv_q && !ID_stall && !flush;

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, cancel_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            cancel_cnt_q <= '0;
        end else begin
            if (IF_stall && fetch_en) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (discard) cancel_cnt_q <= cancel_cnt_q + 1'b1;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_cancel_cnt   = cancel_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = discard ^ (^CNT_W);
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl; the bench itself plays the bus slave.
// Counter checks are included when IF_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_en, ID_stall, flush;
    logic [31:0] IF_inst, IF_pc, IF_bad_inst;
    logic        IF_AdEF_exception, IF_stall, IF_invalid, pc_advance;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_cancel_cnt;
    int          meas_stall = 0;
`endif

    int checks = 0;
    int errors = 0;

    inst_fetch_ctrl_if bus ();

    inst_fetch_ctrl #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .fetch_en         (fetch_en),
        .ID_stall         (ID_stall),
        .flush            (flush),
        .bus              (bus),
        .IF_inst          (IF_inst),
        .IF_pc            (IF_pc),
        .IF_AdEF_exception(IF_AdEF_exception),
        .IF_bad_inst      (IF_bad_inst),
        .IF_stall         (IF_stall),
        .IF_invalid       (IF_invalid),
`ifdef IF_PERF_CNT_EN
        .perf_stall_cycles(perf_stall_cycles),
        .perf_cancel_cnt  (perf_cancel_cnt),
`endif
        .pc_advance       (pc_advance)
    );

    always #5 clk = ~clk;

`ifdef IF_PERF_CNT_EN
    // Inputs are stable from posedge+1 to the next posedge, so negedge sees what that edge sees.
    always @(negedge clk) if (!rst && IF_stall && fetch_en) meas_stall++;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fetch_pc = 32'h0; fetch_en = 1'b0; ID_stall = 1'b0; flush = 1'b1;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;

        // Reset
        tick(); #1;
        chk("rst_stall", {31'b0, IF_stall}, 32'd0);
        chk("rst_invalid", {31'b0, IF_invalid}, 32'd0);
        chk("rst_req", {31'b0, bus.inst_req}, 32'd0);
        tick(); rst = 1'b0; flush = 1'b0; #1;
        chk("rst_pc", IF_pc, RST_PC);
        chk("rst_bad", IF_bad_inst, RST_PC);
        chk("rst_inst", IF_inst, 32'h0);
        chk("rst_adef", {31'b0, IF_AdEF_exception}, 32'd0);
        chk("rst_adv", {31'b0, pc_advance}, 32'd0);
        chk("idle_stall", {31'b0, IF_stall}, 32'd1);
        chk("idle_invalid", {31'b0, IF_invalid}, 32'd0);
        chk("size", {30'b0, bus.inst_size}, 32'd2);
        chk("wr", {31'b0, bus.inst_wr}, 32'd0);

        // Aligned fetch, zero-wait slave
        tick(); fetch_en = 1'b1; fetch_pc = 32'hbfc00000; #1;
        chk("t1_idle_req", {31'b0, bus.inst_req}, 32'd0);
        tick(); bus.inst_addr_ok = 1'b1; #1;
        chk("t1_req", {31'b0, bus.inst_req}, 32'd1);
        chk("t1_addr", bus.inst_addr, 32'hbfc00000);
        tick(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h24080001; #1;
        chk("t1_wait_req", {31'b0, bus.inst_req}, 32'd0);
        chk("t1_wait_stall", {31'b0, IF_stall}, 32'd1);
        tick(); bus.inst_data_ok = 1'b0; fetch_en = 1'b0; #1;
        chk("t1_inst", IF_inst, 32'h24080001);
        chk("t1_pc", IF_pc, 32'hbfc00000);
        chk("t1_adv", {31'b0, pc_advance}, 32'd1);
        chk("t1_stall", {31'b0, IF_stall}, 32'd0);
        tick(); #1;
        chk("t1_adv_once", {31'b0, pc_advance}, 32'd0);
        chk("t1_idle_stall", {31'b0, IF_stall}, 32'd1);

        // Misaligned fetch
        tick(); fetch_en = 1'b1; fetch_pc = 32'hbfc00002; #1;
        chk("t2_req0", {31'b0, bus.inst_req}, 32'd0);
        tick(); fetch_en = 1'b0; ID_stall = 1'b1; #1;
        chk("t2_req1", {31'b0, bus.inst_req}, 32'd0);
        chk("t2_adef", {31'b0, IF_AdEF_exception}, 32'd1);
        chk("t2_bad", IF_bad_inst, 32'hbfc00002);
        chk("t2_inst", IF_inst, 32'h0);
        chk("t2_adv_held", {31'b0, pc_advance}, 32'd0);
        tick(); ID_stall = 1'b0; #1;
        chk("t2_adv", {31'b0, pc_advance}, 32'd1);

        // Flush in REQ, addr_ok three cycles later, response discarded
        tick(); fetch_en = 1'b1; fetch_pc = 32'hbfc00010; #1;
        tick(); flush = 1'b1; #1;
        chk("t3_req_a", {31'b0, bus.inst_req}, 32'd1);
        chk("t3_inv_a", {31'b0, IF_invalid}, 32'd1);
        tick(); flush = 1'b0; fetch_pc = 32'hbfc00020; #1;
        chk("t3_req_b", {31'b0, bus.inst_req}, 32'd1);
        chk("t3_inv_b", {31'b0, IF_invalid}, 32'd1);
        tick(); #1;
        chk("t3_req_c", {31'b0, bus.inst_req}, 32'd1);
        tick(); bus.inst_addr_ok = 1'b1; #1;
        chk("t3_req_d", {31'b0, bus.inst_req}, 32'd1);
        tick(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hdeadbeef; #1;
        chk("t3_cancel_inv", {31'b0, IF_invalid}, 32'd1);
        chk("t3_cancel_adv", {31'b0, pc_advance}, 32'd0);
        chk("t3_cancel_req", {31'b0, bus.inst_req}, 32'd0);
        tick(); bus.inst_data_ok = 1'b0; #1;
        chk("t3_idle_inv", {31'b0, IF_invalid}, 32'd0);
        chk("t3_idle_stall", {31'b0, IF_stall}, 32'd1);
        chk("t3_idle_adv", {31'b0, pc_advance}, 32'd0);
        tick(); bus.inst_addr_ok = 1'b1; #1;
        chk("t3_new_addr", bus.inst_addr, 32'hbfc00020);
        chk("t3_new_req", {31'b0, bus.inst_req}, 32'd1);
        tick(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h11112222; #1;

        // ID_stall for four cycles while READY
        tick(); bus.inst_data_ok = 1'b0; ID_stall = 1'b1; #1;
        chk("t4_inst", IF_inst, 32'h11112222);
        chk("t4_pc", IF_pc, 32'hbfc00020);
        chk("t4_adv0", {31'b0, pc_advance}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("t4_adv_hold", {31'b0, pc_advance}, 32'd0);
            chk("t4_inst_hold", IF_inst, 32'h11112222);
            chk("t4_stall_hold", {31'b0, IF_stall}, 32'd0);
        end
        tick(); ID_stall = 1'b0; #1;
        chk("t4_adv", {31'b0, pc_advance}, 32'd1);
        tick(); fetch_pc = 32'hbfc00030; #1;

        // Flush coincident with data_ok in WAIT
        tick(); bus.inst_addr_ok = 1'b1; #1;
        tick(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; flush = 1'b1;
        bus.inst_rdata = 32'hcafef00d; #1;
        chk("t5_stall", {31'b0, IF_stall}, 32'd1);
        chk("t5_inv", {31'b0, IF_invalid}, 32'd1);
        chk("t5_adv", {31'b0, pc_advance}, 32'd0);
        tick(); bus.inst_data_ok = 1'b0; flush = 1'b0; fetch_en = 1'b0; #1;
        chk("t5_idle_stall", {31'b0, IF_stall}, 32'd1);
        chk("t5_idle_inv", {31'b0, IF_invalid}, 32'd0);
        chk("t5_idle_req", {31'b0, bus.inst_req}, 32'd0);
        tick(); #1;
        chk("t5_still_idle", {31'b0, bus.inst_req}, 32'd0);
        chk("t5_inst_kept", IF_inst, 32'h11112222);
        fetch_en = 1'b1; fetch_pc = 32'hbfc00040;

        // Flush while READY drops the buffer
        tick(); bus.inst_addr_ok = 1'b1; #1;
        tick(); bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h33334444; #1;
        tick(); bus.inst_data_ok = 1'b0; flush = 1'b1; fetch_en = 1'b0; #1;
        chk("t6_adv", {31'b0, pc_advance}, 32'd0);
        chk("t6_stall", {31'b0, IF_stall}, 32'd1);
        tick(); flush = 1'b0; #1;
        chk("t6_idle_adv", {31'b0, pc_advance}, 32'd0);
        chk("t6_idle_stall", {31'b0, IF_stall}, 32'd1);
        chk("t6_idle_req", {31'b0, bus.inst_req}, 32'd0);

`ifdef IF_PERF_CNT_EN
        chk("perf_cancel", perf_cancel_cnt, 32'd2);
        chk("perf_stall", perf_stall_cycles, meas_stall);
`endif

        // Reset mid-transaction, late data_ok ignored
        tick(); fetch_en = 1'b1; fetch_pc = 32'hbfc00050; #1;
        tick(); rst = 1'b1; fetch_en = 1'b0; #1;
        chk("t7_rst_req", {31'b0, bus.inst_req}, 32'd0);
        tick(); rst = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h55556666; #1;
        chk("t7_req", {31'b0, bus.inst_req}, 32'd0);
        chk("t7_adv", {31'b0, pc_advance}, 32'd0);
        chk("t7_pc", IF_pc, RST_PC);
        tick(); bus.inst_data_ok = 1'b0; #1;
        chk("t7_stall", {31'b0, IF_stall}, 32'd1);
        chk("t7_inst", IF_inst, 32'h0);
        chk("t7_req_idle", {31'b0, bus.inst_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Sequences instruction fetch over the SRAM-like instruction bus (req/addr_ok/data_ok) for the IF stage.
- Generates IF_stall, IF_invalid, the fetched instruction and AdEF information consumed by the IF/ID pipeline register.
- Tracks the single outstanding transaction and discards responses belonging to flushed fetches.
- Tells PC logic when to advance.

Parameters:
- RESET_PC, 32'hbfc00000, value of IF_pc and IF_bad_inst after reset.
- CNT_W, 32, width of the performance counters (only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fetch_pc  in  32  PC to fetch; stable while pc_advance=0
- fetch_en  in  1  IF wants to fetch
- ID_stall  in  1  IF/ID cannot accept this cycle
- flush  in  1  redirect (branch, exception, eret); current fetch is wrong-path
- inst_req  out  1  bus request
- inst_wr  out  1  constant 0
- inst_size  out  2  constant 2'b10
- inst_addr  out  32  latched request address
- inst_wdata  out  32  constant 0
- inst_addr_ok  in  1  address accepted
- inst_data_ok  in  1  read data valid
- inst_rdata  in  32  read data
- IF_inst  out  32  fetched instruction (0 on AdEF)
- IF_pc  out  32  PC of IF_inst
- IF_AdEF_exception  out  1  misaligned fetch
- IF_bad_inst  out  32  faulting PC
- IF_stall  out  1  no instruction ready for IF/ID
- IF_invalid  out  1  IF holds nothing valid because of flush
- pc_advance  out  1  one-cycle pulse: instruction handed to IF/ID

Behaviour:
- Reset: state IDLE, cancel=0, inst_req=0, IF_inst=0, IF_pc=RESET_PC, IF_bad_inst=RESET_PC, IF_AdEF_exception=0, buffer-valid bv=0, pc_advance=0. IF_invalid=0 and IF_stall=0 during rst.
- States: IDLE, REQ, WAIT, CANCEL, READY.
- IDLE:
  - fetch_en & ~flush & fetch_pc[1:0]!=0 → READY with AdEF=1, bad_inst=fetch_pc, inst=0. No bus request.
  - fetch_en & ~flush & aligned → latch inst_addr=fetch_pc → REQ.
- REQ:
  - inst_req=1, held until inst_addr_ok.
  - flush in REQ sets cancel; the request is never withdrawn.
  - On addr_ok → CANCEL if cancel|flush, else WAIT.
- WAIT:
  - data_ok & ~flush → capture inst_rdata and IF_pc → READY.
  - flush without data_ok → CANCEL.
  - flush with data_ok → data discarded → IDLE.
- CANCEL: discard the next data_ok → IDLE; clear cancel.
- READY:
  - bv=1. If ~ID_stall: pc_advance=1, bv cleared → IDLE.
  - If ID_stall: hold all outputs.
  - flush in READY: drop the buffer → IDLE, no pc_advance.
- Request rate: at most one transaction outstanding; a new request issues no earlier than the cycle after handover (IDLE to REQ takes one cycle).
- IF_stall = ~bv | flush (combinational); IF/ID loads a bubble when IF_stall & ~ID_stall.
- IF_invalid = flush | (state==CANCEL) | cancel.
- Simultaneous flush and handover: flush wins; pc_advance=0.
- fetch_en low in IDLE: remain idle, IF_stall=1.
- Reset mid-transaction: state returns to IDLE; a late data_ok arriving after rst is ignored in IDLE. The bus slave is reset with the core.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cycles [CNT_W-1:0] and perf_cancel_cnt [CNT_W-1:0].
  - perf_stall_cycles counts cycles with IF_stall=1 & fetch_en=1.
  - perf_cancel_cnt counts responses discarded in CANCEL or WAIT.
  - Both reset to 0 and wrap at 2^CNT_W.
- When undefined, neither port nor counter logic exists.

Test Plan:
- Aligned fetch with zero-wait slave: fetch_pc=bfc00000; addr_ok in REQ cycle, data_ok next cycle with rdata=0x24080001 → IF_inst=0x24080001, IF_pc=bfc00000, pc_advance pulses once, IF_stall low in that cycle.
- Misaligned fetch_pc=bfc00002 → inst_req never asserted; IF_AdEF_exception=1, IF_bad_inst=bfc00002, IF_inst=0.
- Flush in REQ with addr_ok 3 cycles late → inst_req held; data_ok(0xdeadbeef) discarded; IF_invalid high until CANCEL exits; no pc_advance; next fetch uses the new fetch_pc.
- ID_stall high 4 cycles while READY → outputs stable, pc_advance=0; pc_advance fires in the cycle ID_stall falls.
- flush coincident with data_ok in WAIT → data dropped, state IDLE next cycle, IF_stall=1.
- With IF_PERF_CNT_EN: run the flush scenario twice → perf_cancel_cnt=2; perf_stall_cycles equals the measured stall cycles.
